// File: rtl/bsr_chain_pkg.sv
// rtl/bsr_chain_pkg.sv - shared definitions for the s9234 boundary-scan register
//
// Purpose : default cell counts for the s9234 core and the per-cell
//           operation encoding shared by bsr_chain and bsr_cell.
// Chain order: input cells come first. TDI feeds input cell 0, and the last
//           input cell feeds output cell 0. The last output cell drives bsr_tdo.
package bsr_chain_pkg;

  localparam int N_IN_DEF  = 36;  // s9234 core primary inputs
  localparam int N_OUT_DEF = 39;  // s9234 core primary outputs

  // What a cell's capture/shift flop does on the next TCK edge
  typedef enum logic [1:0] {
    CELL_HOLD  = 2'd0,
    CELL_CAPT  = 2'd1,
    CELL_SHIFT = 2'd2
  } cell_op_e;

endpackage

// File: rtl/bsr_cell.sv
// rtl/bsr_cell.sv - one boundary-scan cell (capture/shift flop, update flop, output mux)
//
// Ports:
//   tck       scan clock, rising edge
//   trst_b    synchronous active-low reset
//   op        capture / shift / hold for the cap flop
//   update    load upd from cap (already gated with the BSR select)
//   test_mode 1 = par_out driven from upd, 0 = par_out follows par_in
//   scan_in   serial input from the predecessor cell (or TDI)
//   par_in    parallel input (pin or core output)
//   cap       capture/shift flop, also the serial output to the successor
//   par_out   parallel output (core input or pin)
module bsr_cell
  import bsr_chain_pkg::*;
(
  input  logic     tck,
  input  logic     trst_b,
  input  cell_op_e op,
  input  logic     update,
  input  logic     test_mode,
  input  logic     scan_in,
  input  logic     par_in,
  output logic     cap,
  output logic     par_out
);

  logic upd;

  // upd samples the pre-edge cap, so a simultaneous shift and update
  // latches the old value while the chain still moves.
  always_ff @(posedge tck) begin
    if (!trst_b) begin
      cap <= 1'b0;
      upd <= 1'b0;
    end else begin
      case (op)
        CELL_CAPT:  cap <= par_in;
        CELL_SHIFT: cap <= scan_in;
        default:    cap <= cap;
      endcase
      if (update) begin
        upd <= cap;
      end
    end
  end

  assign par_out = test_mode ? upd : par_in;

endmodule

// File: rtl/bsr_chain.sv
// rtl/bsr_chain.sv - boundary-scan register around the s9234 core primary I/O
//
// Ports:
//   TCK        scan clock, all state changes on its rising edge
//   TRST_b     synchronous active-low reset
//   TDI        serial scan in
//   bsr_capt   capture strobe (captdr already gated with the BSR instruction)
//   shftdr     Shift-DR state, ungated
//   updr       Update-DR state, ungated
//   bsr_sel    BSR instruction active
//   test_mode  1 = update flops drive core inputs and output pins
//   pin_in     chip input pins
//   core_out   core primary outputs
//   core_in    to core primary inputs
//   pin_out    to chip output pins
//   bsr_tdo    serial scan out (last output cell's cap flop, no retiming)
//   shift_cnt  bits shifted since the last capture, saturating at LEN
//   chain_full shift_cnt == LEN
module bsr_chain
  import bsr_chain_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) (
  input  logic                              TCK,
  input  logic                              TRST_b,
  input  logic                              TDI,
  input  logic                              bsr_capt,
  input  logic                              shftdr,
  input  logic                              updr,
  input  logic                              bsr_sel,
  input  logic                              test_mode,
  input  logic [N_IN-1:0]                   pin_in,
  input  logic [N_OUT-1:0]                  core_out,
  output logic [N_IN-1:0]                   core_in,
  output logic [N_OUT-1:0]                  pin_out,
  output logic                              bsr_tdo,
  output logic [$clog2(N_IN+N_OUT+1)-1:0]   shift_cnt,
  output logic                              chain_full
);

  localparam int             LEN   = N_IN + N_OUT;
  localparam int             CW    = $clog2(LEN + 1);
  localparam logic [CW-1:0]  LEN_V = CW'(LEN);

  cell_op_e        op;
  logic            upd_en;
  logic [LEN-1:0]  par_in_all;
  logic [LEN-1:0]  par_out_all;
  logic [LEN:0]    chain;   // chain[k] is the serial input of cell k

  // Capture outranks shift. Capture is not re-gated with bsr_sel because
  // bsr_capt already carries the instruction gating.
  always_comb begin
    op = CELL_HOLD;
    if (bsr_capt) begin
      op = CELL_CAPT;
    end else if (shftdr && bsr_sel) begin
      op = CELL_SHIFT;
    end
  end

  assign upd_en = updr & bsr_sel;

  // Cell k < N_IN is input cell k; cell N_IN+j is output cell j.
  assign par_in_all         = {core_out, pin_in};
  assign {pin_out, core_in} = par_out_all;
  assign chain[0]           = TDI;
  assign bsr_tdo            = chain[LEN];

  for (genvar k = 0; k < LEN; k++) begin : g_cell
    bsr_cell u_cell (
      .tck       (TCK),
      .trst_b    (TRST_b),
      .op        (op),
      .update    (upd_en),
      .test_mode (test_mode),
      .scan_in   (chain[k]),
      .par_in    (par_in_all[k]),
      .cap       (chain[k+1]),
      .par_out   (par_out_all[k])
    );
  end

  always_ff @(posedge TCK) begin
    if (!TRST_b) begin
      shift_cnt <= '0;
    end else if (op == CELL_CAPT) begin
      shift_cnt <= '0;
    end else if (op == CELL_SHIFT && shift_cnt != LEN_V) begin
      shift_cnt <= shift_cnt + 1'b1;
    end
  end

  assign chain_full = (shift_cnt == LEN_V);

endmodule

// File: tb/tb_bsr_chain.sv
// tb/tb_bsr_chain.sv - self-checking bench for bsr_chain
module tb_bsr_chain;

  localparam int N_IN  = 36;
  localparam int N_OUT = 39;
  localparam int LEN   = N_IN + N_OUT;
  localparam int CW    = $clog2(LEN + 1);

  logic             TCK = 1'b0;
  logic             TRST_b, TDI, bsr_capt, shftdr, updr, bsr_sel, test_mode;
  logic [N_IN-1:0]  pin_in;
  logic [N_OUT-1:0] core_out;
  logic [N_IN-1:0]  core_in;
  logic [N_OUT-1:0] pin_out;
  logic             bsr_tdo;
  logic [CW-1:0]    shift_cnt;
  logic             chain_full;

  bsr_chain dut (
    .TCK        (TCK),
    .TRST_b     (TRST_b),
    .TDI        (TDI),
    .bsr_capt   (bsr_capt),
    .shftdr     (shftdr),
    .updr       (updr),
    .bsr_sel    (bsr_sel),
    .test_mode  (test_mode),
    .pin_in     (pin_in),
    .core_out   (core_out),
    .core_in    (core_in),
    .pin_out    (pin_out),
    .bsr_tdo    (bsr_tdo),
    .shift_cnt  (shift_cnt),
    .chain_full (chain_full)
  );

  always #5 TCK = ~TCK;

  int n_pass  = 0;
  int n_total = 0;

  logic [127:0] exp_q[$];

  typedef struct {
    logic             mode;
    logic [N_IN-1:0]  pin;
    logic [N_OUT-1:0] core;
    logic [N_IN-1:0]  exp_core_in;
    logic [N_OUT-1:0] exp_pin_out;
  } vec_t;

  vec_t vecs[6];

  logic [LEN-1:0] p_pat;
  logic [LEN-1:0] cap_m;
  logic [LEN-1:0] upd_m;
  logic [127:0]   exp_v;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // One rising edge, then step 1 time unit away from it before sampling/driving
  task automatic tick();
    @(posedge TCK);
    #1;
  endtask

  initial begin
    TRST_b = 1'b0; TDI = 1'b0; bsr_capt = 1'b0; shftdr = 1'b0; updr = 1'b0;
    bsr_sel = 1'b0; test_mode = 1'b1;
    pin_in = 36'hF_FFFF_FFFF; core_out = 39'h7F_FFFF_FFFF;

    // Reset with test_mode=1: update flops are zero so outputs are zero
    tick();
    chk("reset_core_in",    128'(core_in),    128'd0);
    chk("reset_pin_out",    128'(pin_out),    128'd0);
    chk("reset_tdo",        128'(bsr_tdo),    128'd0);
    chk("reset_shift_cnt",  128'(shift_cnt),  128'd0);
    chk("reset_chain_full", 128'(chain_full), 128'd0);
    TRST_b = 1'b1;

    // Capture, then shift everything out: core_out[38..0] then pin_in[35..0]
    pin_in = 36'h5_A5A5_A5A5; core_out = 39'h3F_0000_FFFF;
    bsr_capt = 1'b1;
    tick();
    bsr_capt = 1'b0;
    chk("capt_shift_cnt", 128'(shift_cnt), 128'd0);
    for (int j = N_OUT - 1; j >= 0; j--) exp_q.push_back(128'(core_out[j]));
    for (int i = N_IN - 1; i >= 0; i--)  exp_q.push_back(128'(pin_in[i]));
    shftdr = 1'b1; bsr_sel = 1'b1;
    for (int k = 0; k < LEN; k++) begin
      exp_v = exp_q.pop_front();
      chk($sformatf("shiftout_tdo_%0d", k), 128'(bsr_tdo), exp_v);
      tick();
    end
    chk("shiftout_cnt",  128'(shift_cnt),  128'd75);
    chk("shiftout_full", 128'(chain_full), 128'd1);

    // Shift in P, MSB first, so in cell 0 ends holding P[0] (the last bit)
    p_pat = LEN'({$urandom, $urandom, $urandom});
    exp_q.push_back(128'(p_pat));
    for (int k = LEN - 1; k >= 0; k--) begin
      TDI = p_pat[k];
      tick();
    end
    chk("shiftin_tdo_latency", 128'(bsr_tdo), 128'(p_pat[LEN-1]));
    shftdr = 1'b0; updr = 1'b1; test_mode = 1'b1;
    tick();
    updr = 1'b0;
    exp_v = exp_q.pop_front();
    chk("update_outputs", 128'({pin_out, core_in}), exp_v);
    upd_m = p_pat;

    // Gating: recapture, shift 3 ones, then assert shftdr/updr with bsr_sel=0
    pin_in = 36'h1_2345_6789; core_out = 39'h76_5432_1ABC;
    bsr_capt = 1'b1;
    tick();
    bsr_capt = 1'b0;
    cap_m = {core_out, pin_in};
    shftdr = 1'b1; TDI = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      cap_m = {cap_m[LEN-2:0], 1'b1};
    end
    bsr_sel = 1'b0; updr = 1'b1;
    for (int k = 0; k < 10; k++) begin
      TDI = k[0];
      tick();
      chk($sformatf("gate_tdo_%0d", k), 128'(bsr_tdo), 128'(cap_m[LEN-1]));
    end
    chk("gate_cnt", 128'(shift_cnt), 128'd3);
    chk("gate_upd", 128'({pin_out, core_in}), 128'(upd_m));
    shftdr = 1'b0; bsr_sel = 1'b1;
    tick();
    updr = 1'b0;
    upd_m = cap_m;
    chk("gate_cap_held", 128'({pin_out, core_in}), 128'(upd_m));

    // Output mux table: test_mode=0 is transparent, test_mode=1 shows upd
    vecs[0] = '{1'b0, 36'h0_0000_0000, 39'h00_0000_0000, 36'h0_0000_0000, 39'h00_0000_0000};
    vecs[1] = '{1'b0, 36'hF_FFFF_FFFF, 39'h7F_FFFF_FFFF, 36'hF_FFFF_FFFF, 39'h7F_FFFF_FFFF};
    vecs[2] = '{1'b0, 36'hA_5A5A_5A5A, 39'h15_5555_5555, 36'hA_5A5A_5A5A, 39'h15_5555_5555};
    vecs[3] = '{1'b0, 36'h0_DEAD_BEEF, 39'h4A_BCDE_F012, 36'h0_DEAD_BEEF, 39'h4A_BCDE_F012};
    vecs[4] = '{1'b1, 36'hF_0F0F_0F0F, 39'h00_1111_2222, upd_m[N_IN-1:0], upd_m[LEN-1:N_IN]};
    vecs[5] = '{1'b0, 36'h3_3333_3333, 39'h66_6666_6666, 36'h3_3333_3333, 39'h66_6666_6666};
    for (int v = 0; v < 6; v++) begin
      test_mode = vecs[v].mode; pin_in = vecs[v].pin; core_out = vecs[v].core;
      #1;
      chk($sformatf("mux_core_in_%0d", v), 128'(core_in), 128'(vecs[v].exp_core_in));
      chk($sformatf("mux_pin_out_%0d", v), 128'(pin_out), 128'(vecs[v].exp_pin_out));
    end

    // Saturation: 80 shifts after a capture
    bsr_capt = 1'b1;
    tick();
    bsr_capt = 1'b0; shftdr = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 74) chk("sat_cnt_74",  128'(shift_cnt),  128'd74);
      if (k == 74) chk("sat_full_74", 128'(chain_full), 128'd0);
    end
    chk("sat_cnt_80",  128'(shift_cnt),  128'd75);
    chk("sat_full_80", 128'(chain_full), 128'd1);

    // Capture and shift in the same cycle: capture wins
    core_out = 39'h40_0000_0000; pin_in = 36'h0_0000_0001;
    bsr_capt = 1'b1; TDI = 1'b0;
    tick();
    bsr_capt = 1'b0;
    chk("coll_cnt",  128'(shift_cnt),  128'd0);
    chk("coll_full", 128'(chain_full), 128'd0);
    chk("coll_tdo",  128'(bsr_tdo),    128'd1);

    // Reset at shift 40, with update also requested: everything clears
    for (int k = 0; k < 40; k++) tick();
    chk("pre_rst_cnt", 128'(shift_cnt), 128'd40);
    TRST_b = 1'b0; updr = 1'b1; test_mode = 1'b1; TDI = 1'b1;
    tick();
    chk("rst_mid_cnt",     128'(shift_cnt),  128'd0);
    chk("rst_mid_tdo",     128'(bsr_tdo),    128'd0);
    chk("rst_mid_outputs", 128'({pin_out, core_in}), 128'd0);
    TRST_b = 1'b1; updr = 1'b0; TDI = 1'b0;
    // A cleared chain shifts out zeros ahead of the new TDI bits
    for (int k = 0; k < LEN; k++) begin
      tick();
      if (k == LEN - 2) chk("rst_chain_zero", 128'(bsr_tdo), 128'd0);
    end
    shftdr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
